vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
- Sequences the physical dispense after the coin-accept FSM has reached a vend state.
- Takes one vend request and its change code, then runs the soda-release actuator handshake.
- Then emits one timed eject pulse per nickel of change, and reports completion or a timeout fault.
- Sits between the coin-accept FSM outputs (soda/change) and the actuator drivers.

Parameters:
- PULSE_CYCLES, 4, width of each coin_eject_o pulse in clk_i cycles (>=1).
- GAP_CYCLES, 4, low time between consecutive eject pulses in cycles (>=1).
- TIMEOUT_CYCLES, 255, max cycles soda_req_o waits for soda_done_i before fault (>=1).
- TMR_W, 8, width of the shared pulse/gap/timeout timer; must hold max(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- vend_valid_i  in  1  vend request; driven from the coin FSM soda output.
- vend_ready_o  out  1  request accepted this cycle when vend_valid_i && vend_ready_o.
- change_i  in  3  change owed, in nickels (0..4); sampled at acceptance.
- soda_req_o  out  1  level request to the soda-release actuator.
- soda_done_i  in  1  actuator completion, sampled only while soda_req_o=1.
- coin_eject_o  out  1  nickel-eject pulse; one pulse per nickel.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle strobe at end of a successful vend.
- fault_o  out  1  sticky timeout fault.
- fault_clr_i  in  1  clears the fault; honoured only in FAULT.

Behaviour:
- Reset (rst_i=1 at a clock edge, any state): state=IDLE, change count=0, timer=0.
- Outputs after reset: soda_req_o, coin_eject_o, done_o, fault_o, busy_o all 0; vend_ready_o=1.
- Reset mid-vend aborts immediately; pending eject pulses are lost.
- vend_ready_o = (state==IDLE), combinational from state.
- Acceptance latches change_i:
  - 5..7 saturate to 4.
  - vend_valid_i is ignored when not IDLE; no queueing.
- States and transitions:
  - IDLE: on accept -> SODA; timer=0.
  - SODA:
    - soda_req_o=1, timer increments each cycle.
    - soda_done_i=1 -> EJECT if count>0, else FINISH; timer=0.
    - Else, timer reaching TIMEOUT_CYCLES-1 -> FAULT.
    - soda_done_i wins if it arrives in the same cycle as the timeout.
  - EJECT:
    - coin_eject_o=1 for exactly PULSE_CYCLES cycles.
    - On the last cycle, count decrements and the block goes to GAP.
  - GAP:
    - coin_eject_o=0 for GAP_CYCLES cycles.
    - Then -> EJECT if count>0, else FINISH.
  - FINISH: done_o=1 for one cycle -> IDLE.
  - FAULT:
    - fault_o=1; soda_req_o=0, coin_eject_o=0.
    - Stays until fault_clr_i=1 -> IDLE (fault_o low the next cycle).
    - Count is discarded.
- Latency, accept to soda_req_o high: 1 cycle (registered state).
- Latency, soda_done_i to first eject edge: 1 cycle.
- Total vend time after soda_done_i with N nickels: N*(PULSE_CYCLES+GAP_CYCLES)+1 cycles to done_o.
- All outputs except vend_ready_o and busy_o are decoded from registered state only; no input-to-output combinational paths.
- soda_done_i outside SODA is ignored.
- fault_clr_i outside FAULT is ignored.

Optional Feature:
- Macro: VEND_EJECT_CNT_EN.
- Defined:
  - Adds output coins_ejected_o [15:0], a free-running count of completed eject pulses.
  - Increments on the last PULSE cycle of each EJECT; wraps 0xFFFF->0.
  - Cleared only by rst_i; not cleared by fault_clr_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Exact-pay vend (PULSE=4, GAP=4, TIMEOUT=255):
  - Stimulus: accept with change_i=0; soda_done_i 10 cycles after soda_req_o rises.
  - Required: zero coin_eject_o pulses; done_o one cycle, 1 cycle after soda_done_i; vend_ready_o back to 1 the next cycle.
- Max change:
  - Stimulus: accept with change_i=4 (from a 40-cent vend).
  - Required: exactly 4 eject pulses, each 4 cycles high, 4 cycles low between; done_o 33 cycles after soda_done_i.
- Saturation and ignore:
  - Stimulus: change_i=7 at accept; vend_valid_i held high throughout the vend.
  - Required: 4 pulses; no second acceptance until IDLE; vend_ready_o=0 while busy_o=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, soda_done_i never asserted.
  - Required: soda_req_o high exactly 8 cycles, then fault_o=1 sticky, with no pulses and no done_o.
  - Then: fault_clr_i pulse -> IDLE; vend_ready_o=1.
- Done/timeout collision and reset mid-eject:
  - Stimulus 1: soda_done_i on the timeout cycle.
  - Required 1: normal completion, fault_o stays 0.
  - Stimulus 2: rst_i during the 2nd eject pulse.
  - Required 2: coin_eject_o 0 the next cycle, all outputs at reset values, no further pulses.
- With VEND_EJECT_CNT_EN:
  - Stimulus: two vends of change 3 and 2.
  - Required: coins_ejected_o=5.
  - Stimulus: preload by forcing to 0xFFFF, one more pulse.
  - Required: coins_ejected_o wraps to 0.

Source files
------------

// File: rtl/vend_dispense_ctrl_if.sv
// rtl/vend_dispense_ctrl_if.sv - vend request, actuator and status bundle for the dispense controller
// coins_ejected_o exists only when VEND_EJECT_CNT_EN is defined.
interface vend_dispense_ctrl_if;
    logic        vend_valid_i;
    logic        vend_ready_o;
    logic [2:0]  change_i;
    logic        soda_req_o;
    logic        soda_done_i;
    logic        coin_eject_o;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic        fault_clr_i;
`ifdef VEND_EJECT_CNT_EN
    logic [15:0] coins_ejected_o;
`endif

    modport slave (
`ifdef VEND_EJECT_CNT_EN
        output coins_ejected_o,
`endif
        input  vend_valid_i, change_i, soda_done_i, fault_clr_i,
        output vend_ready_o, soda_req_o, coin_eject_o, busy_o, done_o, fault_o
    );

    modport master (
`ifdef VEND_EJECT_CNT_EN
        input  coins_ejected_o,
`endif
        output vend_valid_i, change_i, soda_done_i, fault_clr_i,
        input  vend_ready_o, soda_req_o, coin_eject_o, busy_o, done_o, fault_o
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - soda release handshake then timed nickel eject pulses, with timeout fault
// Optional eject counter output enabled by VEND_EJECT_CNT_EN.
module vend_dispense_ctrl #(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMR_W          = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    vend_dispense_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SODA   = 3'd1,
        EJECT  = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cnt;
    logic [2:0]       cnt_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             eject_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tmr_nxt    = tmr;
        eject_last = 1'b0;
        case (state)
            IDLE: begin
                if (bus.vend_valid_i) begin
                    state_nxt = SODA;
                    tmr_nxt   = '0;
                    cnt_nxt   = (bus.change_i > 3'd4) ? 3'd4 : bus.change_i;
                end
            end
            SODA: begin
                // completion beats a timeout landing on the same cycle
                if (bus.soda_done_i) begin
                    state_nxt = (cnt != 3'd0) ? EJECT : FINISH;
                    tmr_nxt   = '0;
                end else if (tmr == TIMEOUT_LAST) begin
                    state_nxt = FAULT;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            EJECT: begin
                if (tmr == PULSE_LAST) begin
                    eject_last = 1'b1;
                    cnt_nxt    = cnt - 3'd1;
                    state_nxt  = GAP;
                    tmr_nxt    = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    state_nxt = (cnt != 3'd0) ? EJECT : FINISH;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                cnt_nxt = 3'd0;
                if (bus.fault_clr_i) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
                tmr_nxt   = '0;
            end
        endcase
    end

    assign bus.vend_ready_o = (state == IDLE);
    assign bus.busy_o       = (state != IDLE);
    assign bus.soda_req_o   = (state == SODA);
    assign bus.coin_eject_o = (state == EJECT);
    assign bus.done_o       = (state == FINISH);
    assign bus.fault_o      = (state == FAULT);

`ifdef VEND_EJECT_CNT_EN
    logic [15:0] eject_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eject_cnt <= 16'd0;
        end else if (eject_last) begin
            eject_cnt <= eject_cnt + 16'd1;
        end
    end

    assign bus.coins_ejected_o = eject_cnt;
`endif
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb/tb_vend_dispense_ctrl.sv - randomized vends on two instances (timeout 255 and 8) against a timeline model
module tb_vend_dispense_ctrl;
    localparam int P    = 4;
    localparam int G    = 4;
    localparam int TO_A = 255;
    localparam int TO_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] cnt_a = 16'd0;
    logic [15:0] cnt_b = 16'd0;

    always #5 clk = ~clk;

    vend_dispense_ctrl_if bus_a ();
    vend_dispense_ctrl_if bus_b ();

    vend_dispense_ctrl dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    vend_dispense_ctrl #(.TIMEOUT_CYCLES(TO_B)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    // {ready, busy, soda_req, coin_eject, done, fault}
    logic [5:0] obs_a;
    logic [5:0] obs_b;
    assign obs_a = {bus_a.vend_ready_o, bus_a.busy_o, bus_a.soda_req_o,
                    bus_a.coin_eject_o, bus_a.done_o, bus_a.fault_o};
    assign obs_b = {bus_b.vend_ready_o, bus_b.busy_o, bus_b.soda_req_o,
                    bus_b.coin_eject_o, bus_b.done_o, bus_b.fault_o};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [2:0] chg, input logic done, input logic clr);
        bus_a.vend_valid_i = valid;  bus_b.vend_valid_i = valid;
        bus_a.change_i     = chg;    bus_b.change_i     = chg;
        bus_a.soda_done_i  = done;   bus_b.soda_done_i  = done;
        bus_a.fault_clr_i  = clr;    bus_b.fault_clr_i  = clr;
    endtask

    // Cycle index of the last busy cycle: the done strobe, or the first fault cycle.
    function automatic int end_of(input int t, input int d, input int n);
        return (d < t) ? d + n * (P + G) + 1 : t;
    endfunction

    // Expected outputs k cycles after the accept edge, from the vend timeline rules.
    function automatic logic [5:0] exp_vec(input int t, input int k, input int d, input int n, input int clr);
        int m;
        if (d < t) begin
            if (k <= d) return 6'b011000;
            if (k < end_of(t, d, n)) begin
                m = k - d - 1;
                return ((m % (P + G)) < P) ? 6'b010100 : 6'b010000;
            end
            if (k == end_of(t, d, n)) return 6'b010010;
            return 6'b100000;
        end
        if (k < t) return 6'b011000;
        if (k <= clr) return 6'b010001;
        return 6'b100000;
    endfunction

    task automatic idle_noise(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            check("idle_a", 16'(obs_a), 16'h20);
            check("idle_b", 16'(obs_b), 16'h20);
        end
    endtask

    task automatic run_vend(input int chg, input int d, input bit hold, input int abort_k);
        int n;
        int ea;
        int eb;
        int clr;
        int kmax;
        n    = (chg > 4) ? 4 : chg;
        ea   = end_of(TO_A, d, n);
        eb   = end_of(TO_B, d, n);
        clr  = ((ea > eb) ? ea : eb) + 1;
        kmax = clr + 3;
        @(negedge clk);
        drive(1'b1, 3'(chg), 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 0; k < kmax; k++) begin
            #1;
            drive(1'(hold && (k <= ea)), 3'($urandom_range(0, 7)), 1'(k == d), 1'(k == clr));
            rst = (k == abort_k);
            @(negedge clk);
            check($sformatf("a_c%0d_d%0d_k%0d", chg, d, k), 16'(obs_a), 16'(exp_vec(TO_A, k, d, n, clr)));
            check($sformatf("b_c%0d_d%0d_k%0d", chg, d, k), 16'(obs_b), 16'(exp_vec(TO_B, k, d, n, clr)));
            @(posedge clk);
            if (k == abort_k) begin
                #1;
                rst = 1'b0;
                drive(1'b0, 3'd0, 1'b0, 1'b0);
                cnt_a = 16'd0;
                cnt_b = 16'd0;
                @(negedge clk);
                check("abort_a", 16'(obs_a), 16'h20);
                check("abort_b", 16'(obs_b), 16'h20);
                return;
            end
        end
        #1;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        if (d < TO_A) cnt_a = cnt_a + 16'(n);
        if (d < TO_B) cnt_b = cnt_b + 16'(n);
`ifdef VEND_EJECT_CNT_EN
        check("cnt_a", bus_a.coins_ejected_o, cnt_a);
        check("cnt_b", bus_b.coins_ejected_o, cnt_b);
`endif
    endtask

    initial begin
        int d;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", 16'(obs_a), 16'h20);
        check("reset_b", 16'(obs_b), 16'h20);
`ifdef VEND_EJECT_CNT_EN
        check("reset_cnt_a", bus_a.coins_ejected_o, 16'd0);
`endif
        rst = 1'b0;
        idle_noise(5);

        run_vend(0, 10, 1'b0, -1);
        idle_noise(2);
        run_vend(4, 3, 1'b0, -1);
        idle_noise(2);
        run_vend(7, 5, 1'b1, -1);
        idle_noise(2);
        run_vend(2, 1000, 1'b0, -1);
        idle_noise(2);
        run_vend(3, TO_B - 1, 1'b0, -1);
        idle_noise(2);
        run_vend(1, TO_A - 1, 1'b0, -1);
        idle_noise(2);
        run_vend(3, 2, 1'b0, -1);
        run_vend(2, 2, 1'b0, -1);
        idle_noise(2);

        for (int i = 0; i < 15; i++) begin
            d = $urandom_range(0, 12);
            run_vend($urandom_range(0, 7), d, (d < TO_B) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
            idle_noise($urandom_range(1, 4));
        end

`ifdef VEND_EJECT_CNT_EN
        @(posedge clk);
        #1;
        force dut_a.eject_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_a.eject_cnt;
        cnt_a = 16'hFFFF;
        run_vend(1, 2, 1'b0, -1);
        idle_noise(1);
`endif

        run_vend(4, 2, 1'b0, 2 + 1 + P + G + 1);
        idle_noise(20);
`ifdef VEND_EJECT_CNT_EN
        check("cnt_after_rst", bus_a.coins_ejected_o, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
